// File: rtl/tex_fetch_unit_pkg.sv
// rtl/tex_fetch_unit_pkg.sv - shared texel fetch types, format codes and CLUT address helper
package tex_fetch_unit_pkg;

  localparam logic [1:0] PIX_4BIT     = 2'd0;
  localparam logic [1:0] PIX_8BIT     = 2'd1;
  localparam logic [1:0] PIX_16BIT    = 2'd2;
  localparam logic [1:0] PIX_RESERVED = 2'd3;

  typedef logic [18:0] vram_addr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TEX_CHK,
    ST_TEX_REQ,
    ST_TEX_WAIT,
    ST_CLUT_CHK,
    ST_CLUT_REQ,
    ST_CLUT_WAIT,
    ST_OUT
  } fetch_state_t;

  // CLUT X wraps inside the 1024-halfword line; there is no carry into Y.
  function automatic vram_addr_t clut_addr(input logic [8:0] clut_y,
                                           input logic [5:0] clut_x,
                                           input logic [7:0] idx8);
    logic [9:0] x;
    x = {clut_x, 4'd0} + {2'd0, idx8};
    return {clut_y, x};
  endfunction

endpackage

// File: rtl/tex_index_extract.sv
// rtl/tex_index_extract.sv - palette index extraction from a VRAM halfword
module tex_index_extract
  import tex_fetch_unit_pkg::*;
(
  input  logic [15:0] halfword,
  input  logic [1:0]  tex_format,
  input  logic [1:0]  sub_sel,
  output logic [7:0]  idx8,
  output logic        palettized
);

  logic [3:0] nibble;

  always_comb begin
    case (sub_sel)
      2'd0:    nibble = halfword[3:0];
      2'd1:    nibble = halfword[7:4];
      2'd2:    nibble = halfword[11:8];
      default: nibble = halfword[15:12];
    endcase
  end

  always_comb begin
    idx8       = 8'd0;
    palettized = 1'b0;
    case (tex_format)
      PIX_4BIT: begin
        idx8       = {4'd0, nibble};
        palettized = 1'b1;
      end
      PIX_8BIT: begin
        idx8       = sub_sel[0] ? halfword[15:8] : halfword[7:0];
        palettized = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/tex_fetch_unit.sv
// rtl/tex_fetch_unit.sv - per-lane texel fetch: VRAM halfword read, index extract, CLUT lookup
module tex_fetch_unit
  import tex_fetch_unit_pkg::*;
#(
  parameter bit USE_HIT_CACHE = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_reqValid,
  output logic        o_reqReady,
  input  logic [18:0] i_texAddr,
  input  logic [1:0]  i_subSel,
  input  logic [1:0]  i_texFormat,
  input  logic [5:0]  i_clutX,
  input  logic [8:0]  i_clutY,
  input  logic        i_invalidate,
  output logic        o_memReq,
  output logic [18:0] o_memAddr,
  input  logic        i_memAck,
  input  logic        i_memDataValid,
  input  logic [15:0] i_memData,
  output logic        o_texValid,
  input  logic        i_texReady,
  output logic [15:0] o_texel
);

  fetch_state_t state, state_next;

  vram_addr_t  tex_addr_q;
  logic [1:0]  sub_sel_q;
  logic [1:0]  fmt_q;
  logic [5:0]  clut_x_q;
  logic [8:0]  clut_y_q;
  logic [7:0]  idx_q;
  logic [15:0] texel_q;

  logic        tex_hit_valid;
  vram_addr_t  tex_hit_addr;
  logic [15:0] tex_hit_data;
  logic        clut_hit_valid;
  vram_addr_t  clut_hit_addr;
  logic [15:0] clut_hit_data;

  logic        accept;
  logic        tex_use;
  logic        tex_fill;
  logic        clut_use;
  logic        clut_fill;

  logic [15:0] tex_word;
  logic [15:0] clut_word;
  logic [7:0]  idx8;
  logic        palettized;
  vram_addr_t  clut_addr_w;
  logic        tex_hit;
  logic        clut_hit;

  // The CHK states read the hit register; the WAIT states read returning memory data.
  assign tex_word    = (state == ST_TEX_CHK)  ? tex_hit_data  : i_memData;
  assign clut_word   = (state == ST_CLUT_CHK) ? clut_hit_data : i_memData;
  assign clut_addr_w = clut_addr(clut_y_q, clut_x_q, idx_q);
  assign tex_hit     = USE_HIT_CACHE && tex_hit_valid  && (tex_hit_addr  == tex_addr_q);
  assign clut_hit    = USE_HIT_CACHE && clut_hit_valid && (clut_hit_addr == clut_addr_w);
  assign o_texel     = texel_q;

  tex_index_extract u_extract (
    .halfword   (tex_word),
    .tex_format (fmt_q),
    .sub_sel    (sub_sel_q),
    .idx8       (idx8),
    .palettized (palettized)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    o_reqReady = 1'b0;
    o_memReq   = 1'b0;
    o_memAddr  = '0;
    o_texValid = 1'b0;
    accept     = 1'b0;
    tex_use    = 1'b0;
    tex_fill   = 1'b0;
    clut_use   = 1'b0;
    clut_fill  = 1'b0;
    case (state)
      ST_IDLE: begin
        o_reqReady = !i_rst;
        if (i_reqValid && !i_rst) begin
          accept     = 1'b1;
          state_next = ST_TEX_CHK;
        end
      end
      ST_TEX_CHK: begin
        if (tex_hit) begin
          tex_use    = 1'b1;
          state_next = palettized ? ST_CLUT_CHK : ST_OUT;
        end else begin
          state_next = ST_TEX_REQ;
        end
      end
      ST_TEX_REQ: begin
        o_memReq  = 1'b1;
        o_memAddr = tex_addr_q;
        if (i_memAck) state_next = ST_TEX_WAIT;
      end
      ST_TEX_WAIT: begin
        if (i_memDataValid) begin
          tex_use    = 1'b1;
          tex_fill   = 1'b1;
          state_next = palettized ? ST_CLUT_CHK : ST_OUT;
        end
      end
      ST_CLUT_CHK: begin
        if (clut_hit) begin
          clut_use   = 1'b1;
          state_next = ST_OUT;
        end else begin
          state_next = ST_CLUT_REQ;
        end
      end
      ST_CLUT_REQ: begin
        o_memReq  = 1'b1;
        o_memAddr = clut_addr_w;
        if (i_memAck) state_next = ST_CLUT_WAIT;
      end
      ST_CLUT_WAIT: begin
        if (i_memDataValid) begin
          clut_use   = 1'b1;
          clut_fill  = 1'b1;
          state_next = ST_OUT;
        end
      end
      ST_OUT: begin
        o_texValid = 1'b1;
        if (i_texReady) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tex_addr_q     <= '0;
      sub_sel_q      <= '0;
      fmt_q          <= '0;
      clut_x_q       <= '0;
      clut_y_q       <= '0;
      idx_q          <= '0;
      texel_q        <= '0;
      tex_hit_valid  <= 1'b0;
      tex_hit_addr   <= '0;
      tex_hit_data   <= '0;
      clut_hit_valid <= 1'b0;
      clut_hit_addr  <= '0;
      clut_hit_data  <= '0;
    end else begin
      if (accept) begin
        tex_addr_q <= i_texAddr;
        sub_sel_q  <= i_subSel;
        fmt_q      <= i_texFormat;
        clut_x_q   <= i_clutX;
        clut_y_q   <= i_clutY;
      end
      if (tex_use) begin
        if (palettized) idx_q   <= idx8;
        else            texel_q <= tex_word;
      end
      if (clut_use) texel_q <= clut_word;
      if (tex_fill && USE_HIT_CACHE) begin
        tex_hit_valid <= 1'b1;
        tex_hit_addr  <= tex_addr_q;
        tex_hit_data  <= i_memData;
      end
      if (clut_fill && USE_HIT_CACHE) begin
        clut_hit_valid <= 1'b1;
        clut_hit_addr  <= clut_addr_w;
        clut_hit_data  <= i_memData;
      end
      // Invalidate wins over a same-cycle fill: that data is used once but never marked valid.
      if (i_invalidate) begin
        tex_hit_valid  <= 1'b0;
        clut_hit_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tex_fetch_unit.sv
// tb/tb_tex_fetch_unit.sv - directed self-checking bench for tex_fetch_unit
module tb_tex_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [18:0] tex_addr = '0;
  logic [1:0]  sub_sel = '0;
  logic [1:0]  tex_format = '0;
  logic [5:0]  clut_x = '0;
  logic [8:0]  clut_y = '0;
  logic        invalidate = 1'b0;
  logic        mem_req;
  logic [18:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic        mem_dv = 1'b0;
  logic [15:0] mem_data = '0;
  logic        tex_valid;
  logic        tex_ready = 1'b0;
  logic [15:0] texel;

  int checks = 0;
  int failures = 0;
  int req_count = 0;
  int snap;

  tex_fetch_unit #(.USE_HIT_CACHE(1'b1)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_reqValid     (req_valid),
    .o_reqReady     (req_ready),
    .i_texAddr      (tex_addr),
    .i_subSel       (sub_sel),
    .i_texFormat    (tex_format),
    .i_clutX        (clut_x),
    .i_clutY        (clut_y),
    .i_invalidate   (invalidate),
    .o_memReq       (mem_req),
    .o_memAddr      (mem_addr),
    .i_memAck       (mem_ack),
    .i_memDataValid (mem_dv),
    .i_memData      (mem_data),
    .o_texValid     (tex_valid),
    .i_texReady     (tex_ready),
    .o_texel        (texel)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_req && mem_ack) req_count <= req_count + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_req(input logic [18:0] a, input logic [1:0] s, input logic [1:0] f,
                          input logic [5:0] cx, input logic [8:0] cy);
    int n;
    n = 0;
    tex_addr = a; sub_sel = s; tex_format = f; clut_x = cx; clut_y = cy;
    req_valid = 1'b1;
    while (!req_ready && n < 100) begin tick(); n++; end
    check("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic serve_read(input logic [18:0] exp_addr, input logic [15:0] data,
                            input int lat, input bit inv, input string tag);
    int n;
    n = 0;
    while (!mem_req && n < 100) begin tick(); n++; end
    check({tag, "_req_seen"}, {31'd0, mem_req}, 32'd1);
    check({tag, "_addr"}, {13'd0, mem_addr}, {13'd0, exp_addr});
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    repeat (lat - 1) tick();
    mem_dv = 1'b1; mem_data = data; invalidate = inv;
    tick();
    mem_dv = 1'b0; mem_data = 16'h0; invalidate = 1'b0;
  endtask

  task automatic wait_tex(input logic [15:0] exp, input int exp_lat, input string tag);
    int n;
    n = 1;
    while (!tex_valid && n < 200) begin tick(); n++; end
    check({tag, "_valid"}, {31'd0, tex_valid}, 32'd1);
    if (exp_lat > 0) check({tag, "_latency"}, n, exp_lat);
    check({tag, "_texel"}, {16'd0, texel}, {16'd0, exp});
    repeat (2) begin
      tick();
      check({tag, "_held_valid"}, {31'd0, tex_valid}, 32'd1);
      check({tag, "_held_texel"}, {16'd0, texel}, {16'd0, exp});
    end
    tex_ready = 1'b1;
    tick();
    tex_ready = 1'b0;
    check({tag, "_consumed"}, {31'd0, tex_valid}, 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", {13'd0, mem_addr}, 32'd0);
    check("rst_tex_valid", {31'd0, tex_valid}, 32'd0);
    check("rst_texel", {16'd0, texel}, 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

    // 16-bit miss, then identical 16-bit hit at T+2
    snap = req_count;
    send_req(19'h12345, 2'd0, 2'd2, 6'd0, 9'd0);
    serve_read(19'h12345, 16'hBEEF, 3, 1'b0, "t16_read");
    wait_tex(16'hBEEF, 0, "t16");
    check("t16_one_memreq", req_count - snap, 32'd1);
    snap = req_count;
    send_req(19'h12345, 2'd0, 2'd2, 6'd0, 9'd0);
    wait_tex(16'hBEEF, 2, "t16_hit");
    check("t16_hit_no_memreq", req_count - snap, 32'd0);

    // 4-bit: idx 0xA, CLUT at {5, 48+10}
    snap = req_count;
    send_req(19'h00100, 2'd2, 2'd0, 6'd3, 9'd5);
    serve_read(19'h00100, 16'h0A50, 1, 1'b0, "t4_tex");
    serve_read(19'h0143A, 16'h7C1F, 2, 1'b0, "t4_clut");
    wait_tex(16'h7C1F, 0, "t4");
    check("t4_two_memreq", req_count - snap, 32'd2);

    // Identical 4-bit request hits both entries: T+3, no memory traffic
    snap = req_count;
    send_req(19'h00100, 2'd2, 2'd0, 6'd3, 9'd5);
    wait_tex(16'h7C1F, 3, "t4_hit");
    check("t4_hit_no_memreq", req_count - snap, 32'd0);

    // Invalidate while idle, then repeat: both reads again
    invalidate = 1'b1;
    tick();
    invalidate = 1'b0;
    snap = req_count;
    send_req(19'h00100, 2'd2, 2'd0, 6'd3, 9'd5);
    serve_read(19'h00100, 16'h0A50, 1, 1'b0, "t4_inv_tex");
    serve_read(19'h0143A, 16'h03E0, 1, 1'b0, "t4_inv_clut");
    wait_tex(16'h03E0, 0, "t4_inv");
    check("t4_inv_two_memreq", req_count - snap, 32'd2);

    // 8-bit, high byte, CLUT X wraps: (1008+255) mod 1024 = 239 on line 7
    snap = req_count;
    send_req(19'h00200, 2'd1, 2'd1, 6'd63, 9'd7);
    serve_read(19'h00200, 16'hFF00, 2, 1'b0, "t8_tex");
    serve_read(19'h01CEF, 16'h1234, 1, 1'b0, "t8_clut");
    wait_tex(16'h1234, 0, "t8");
    check("t8_two_memreq", req_count - snap, 32'd2);

    // Invalidate coincident with fill: texel correct, next identical request refetches
    send_req(19'h00300, 2'd0, 2'd2, 6'd0, 9'd0);
    serve_read(19'h00300, 16'h8001, 1, 1'b1, "inv_fill");
    wait_tex(16'h8001, 0, "inv_fill");
    snap = req_count;
    send_req(19'h00300, 2'd0, 2'd2, 6'd0, 9'd0);
    serve_read(19'h00300, 16'h8002, 1, 1'b0, "inv_refetch");
    wait_tex(16'h8002, 0, "inv_refetch");
    check("inv_refetch_memreq", req_count - snap, 32'd1);

    // Arbiter stalls: request and address hold for 10 cycles
    send_req(19'h00400, 2'd0, 2'd2, 6'd0, 9'd0);
    tick();
    for (int i = 0; i < 10; i++) begin
      check("stall_mem_req", {31'd0, mem_req}, 32'd1);
      check("stall_mem_addr", {13'd0, mem_addr}, 32'h00400);
      tick();
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    check("wait_no_req", {31'd0, mem_req}, 32'd0);

    // Reset inside TEX_WAIT, then a late data beat
    rst = 1'b1;
    tick();
    rst = 1'b0;
    snap = req_count;
    mem_dv = 1'b1; mem_data = 16'hDEAD;
    tick();
    mem_dv = 1'b0; mem_data = 16'h0;
    repeat (3) tick();
    check("late_tex_valid", {31'd0, tex_valid}, 32'd0);
    check("late_texel", {16'd0, texel}, 32'd0);
    check("late_mem_req", {31'd0, mem_req}, 32'd0);
    check("late_mem_addr", {13'd0, mem_addr}, 32'd0);
    check("late_idle_ready", {31'd0, req_ready}, 32'd1);
    check("late_no_memreq", req_count - snap, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
